// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake game controller and its datapath/board.
//   master : the datapath side (drives buttons, collision, apple_eaten)
//   slave  : the controller side (drives game_mode, choice, board_w, dir,
//            move_tick, start, score)
interface snake_game_ctrl_if;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       collision;
  logic       apple_eaten;
  logic [1:0] game_mode;
  logic [1:0] choice;
  logic [3:0] board_w;
  logic [1:0] dir;
  logic       move_tick;
  logic       start;
  logic [7:0] score;

  modport master (
    output up, down, left, right, collision, apple_eaten,
    input  game_mode, choice, board_w, dir, move_tick, start, score
  );

  modport slave (
    input  up, down, left, right, collision, apple_eaten,
    output game_mode, choice, board_w, dir, move_tick, start, score
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game control FSM: menu selection, game start, heading control,
// move-tick timing with speed-up on apples, game-over handling.
// Ports:
//   clk      : clock, all state updates on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : snake_game_ctrl_if.slave (buttons, collision, apple_eaten in;
//              game_mode, choice, board_w, dir, move_tick, start, score out)
//
// state | meaning
// MENU  | choose board size with left/right, up starts a game
// PLAY  | snake moving, move_tick every period cycles
// OVER  | game ended by collision, any press returns to MENU
module snake_game_ctrl #(
  parameter int MOVE_PERIOD = 10000000,
  parameter int MIN_PERIOD  = 2000000,
  parameter int SPEED_STEP  = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  snake_game_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    MENU = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } mode_e;

  localparam logic [23:0] MOVE_P = 24'(MOVE_PERIOD);
  localparam logic [23:0] MIN_P  = 24'(MIN_PERIOD);
  localparam logic [23:0] STEP_P = 24'(SPEED_STEP);

  mode_e       mode_q;
  logic [1:0]  choice_q;
  logic [3:0]  board_w_q;
  logic [1:0]  dir_q;
  logic [1:0]  pend_q;
  logic        tick_q;
  logic        start_q;
  logic [7:0]  score_q;
  logic [23:0] cnt_q;
  logic [23:0] period_q;
  logic [3:0]  btn_q;

  logic [3:0]  btn_now;
  logic [3:0]  press;
  logic        any_press;
  logic [1:0]  sel_dir;
  logic [3:0]  board_w_d;
  logic [23:0] period_d;
  logic [24:0] dec_floor;
  logic        tick_hit;

  // bit order: up, down, left, right (priority high to low)
  assign btn_now   = {bus.up, bus.down, bus.left, bus.right};
  assign press     = btn_now & ~btn_q;
  assign any_press = |press;

  always_comb begin
    sel_dir = 2'b00;
    if (press[3])      sel_dir = 2'b10;
    else if (press[2]) sel_dir = 2'b11;
    else if (press[1]) sel_dir = 2'b01;
    else               sel_dir = 2'b00;
  end

  always_comb begin
    board_w_d = 4'd10;
    case (choice_q)
      2'd0:    board_w_d = 4'd6;
      2'd1:    board_w_d = 4'd8;
      default: board_w_d = 4'd10;
    endcase
  end

  // Subtract only when the result stays at or above the floor; the compare
  // is done one bit wider so MIN+STEP cannot wrap.
  assign dec_floor = {1'b0, MIN_P} + {1'b0, STEP_P};
  assign period_d  = ({1'b0, period_q} >= dec_floor) ? (period_q - STEP_P) : MIN_P;

  // >= rather than == so a period shortened below the running count still
  // produces a tick on the next cycle instead of letting the counter run away.
  assign tick_hit = (cnt_q >= (period_q - 24'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= MENU;
      choice_q  <= 2'd0;
      board_w_q <= 4'd10;
      dir_q     <= 2'b00;
      pend_q    <= 2'b00;
      tick_q    <= 1'b0;
      start_q   <= 1'b0;
      score_q   <= 8'd0;
      cnt_q     <= 24'd0;
      period_q  <= MOVE_P;
      // buttons held through reset must be released before they count
      btn_q     <= 4'b1111;
    end else begin
      btn_q   <= btn_now;
      start_q <= 1'b0;
      tick_q  <= 1'b0;
      case (mode_q)
        MENU: begin
          if (press[3]) begin
            board_w_q <= board_w_d;
            start_q   <= 1'b1;
            mode_q    <= PLAY;
            dir_q     <= 2'b00;
            pend_q    <= 2'b00;
            score_q   <= 8'd0;
            cnt_q     <= 24'd0;
            period_q  <= MOVE_P;
          end else if (press[2]) begin
            choice_q <= choice_q;
          end else if (press[1]) begin
            if (choice_q != 2'd0) choice_q <= choice_q - 2'd1;
          end else if (press[0]) begin
            if (choice_q < 2'd2) choice_q <= choice_q + 2'd1;
          end
        end
        PLAY: begin
          if (bus.collision) begin
            mode_q <= OVER;
          end else begin
            if (tick_hit) begin
              cnt_q  <= 24'd0;
              tick_q <= 1'b1;
              dir_q  <= pend_q;
            end else begin
              cnt_q <= cnt_q + 24'd1;
            end
            // reversal check uses the committed heading before this edge;
            // opposite headings differ only in the LSB
            if (any_press && (sel_dir != (dir_q ^ 2'b01))) pend_q <= sel_dir;
            if (bus.apple_eaten) begin
              if (score_q != 8'hFF) score_q <= score_q + 8'd1;
              period_q <= period_d;
            end
          end
        end
        OVER: begin
          if (any_press) begin
            mode_q   <= MENU;
            choice_q <= 2'd0;
          end
        end
        default: mode_q <= MENU;
      endcase
    end
  end

  assign bus.game_mode = mode_q;
  assign bus.choice    = choice_q;
  assign bus.board_w   = board_w_q;
  assign bus.dir       = dir_q;
  assign bus.move_tick = tick_q;
  assign bus.start     = start_q;
  assign bus.score     = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Testbench for snake_game_ctrl with MOVE_PERIOD=8, MIN_PERIOD=4, SPEED_STEP=2.
// Expected move_tick events (spacing since previous tick/start, heading) are
// queued by the tests and checked by a monitor when the DUT ticks.
module tb_snake_game_ctrl;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   cyc_n;
  int   last_ev;

  typedef struct {
    int         gap;
    logic [1:0] dir;
  } tick_exp_t;

  tick_exp_t exp_q[$];

  snake_game_ctrl_if bus();

  snake_game_ctrl #(
    .MOVE_PERIOD(8),
    .MIN_PERIOD (4),
    .SPEED_STEP (2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  // scoreboard monitor: pops one expectation per observed move_tick
  always @(negedge clk) begin
    if (bus.start === 1'b1) last_ev = cyc_n;
    if (bus.move_tick === 1'b1) begin
      tick_exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tick: move_tick=1 at cycle %0d, required no tick", cyc_n);
      end else begin
        e = exp_q.pop_front();
        if ((cyc_n - last_ev) !== e.gap || bus.dir !== e.dir) begin
          bad++;
          $display("FAIL tick_spacing: gap=%0d dir=%b, required gap=%0d dir=%b",
                   cyc_n - last_ev, bus.dir, e.gap, e.dir);
        end
      end
      last_ev = cyc_n;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.up    = v;
      1: bus.down  = v;
      2: bus.left  = v;
      default: bus.right = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc();
    set_btn(b, 1'b0);
    cyc();
  endtask

  // waits until every queued tick was seen; leaves us just after the
  // negedge of the last tick cycle
  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d ticks, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0;
    bus.collision = 0; bus.apple_eaten = 0;
    repeat (3) cyc();
    total++;
    if (bus.game_mode !== 2'b00 || bus.choice !== 2'd0 || bus.board_w !== 4'd10 ||
        bus.dir !== 2'b00 || bus.move_tick !== 1'b0 || bus.start !== 1'b0 ||
        bus.score !== 8'd0) begin
      bad++;
      $display("FAIL reset_values: mode=%b choice=%0d bw=%0d dir=%b tick=%b start=%b score=%0d, required 00/0/10/00/0/0/0",
               bus.game_mode, bus.choice, bus.board_w, bus.dir, bus.move_tick, bus.start, bus.score);
    end
    reset_n = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_menu_start();
    logic [1:0] exp_c[5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
    int         btns[5]  = '{3, 3, 3, 1, 2};
    for (int i = 0; i < 5; i++) begin
      press(btns[i]);
      total++;
      if (bus.choice !== exp_c[i]) begin
        bad++;
        $display("FAIL menu_choice_%0d: choice=%0d, required %0d", i, bus.choice, exp_c[i]);
      end
    end
    press(3);
    bus.up = 1'b1;
    cyc();
    total++;
    if (bus.start !== 1'b1 || bus.game_mode !== 2'b01 || bus.board_w !== 4'd10 || bus.score !== 8'd0) begin
      bad++;
      $display("FAIL menu_start: start=%b mode=%b bw=%0d score=%0d, required 1/01/10/0",
               bus.start, bus.game_mode, bus.board_w, bus.score);
    end
    bus.up = 1'b0;
    cyc();
    total++;
    if (bus.start !== 1'b0) begin
      bad++;
      $display("FAIL start_width: start=%b, required 0", bus.start);
    end
  endtask

  task automatic test_idle_ticks();
    for (int i = 0; i < 3; i++) exp_q.push_back('{8, 2'b00});
    wait_drain(60, "idle");
    total++;
    if (bus.dir !== 2'b00) begin
      bad++;
      $display("FAIL idle_dir: dir=%b, required 00", bus.dir);
    end
  endtask

  task automatic test_heading();
    exp_q.push_back('{8, 2'b10});
    press(2);
    press(0);
    total++;
    if (bus.dir !== 2'b00) begin
      bad++;
      $display("FAIL heading_early: dir=%b, required 00", bus.dir);
    end
    wait_drain(20, "heading_up");
    total++;
    if (bus.dir !== 2'b10) begin
      bad++;
      $display("FAIL heading_up: dir=%b, required 10", bus.dir);
    end
    exp_q.push_back('{8, 2'b01});
    press(1);
    press(2);
    wait_drain(20, "heading_left");
  endtask

  task automatic test_apples();
    int gaps[3] = '{6, 4, 4};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{gaps[i], 2'b01});
      bus.apple_eaten = 1'b1;
      cyc();
      bus.apple_eaten = 1'b0;
      wait_drain(20, "apple");
      total++;
      if (bus.score !== 8'(i + 1)) begin
        bad++;
        $display("FAIL apple_score_%0d: score=%0d, required %0d", i, bus.score, i + 1);
      end
    end
  endtask

  task automatic test_collision();
    bus.collision   = 1'b1;
    bus.apple_eaten = 1'b1;
    cyc();
    bus.collision   = 1'b0;
    bus.apple_eaten = 1'b0;
    total++;
    if (bus.game_mode !== 2'b10 || bus.score !== 8'd3 || bus.move_tick !== 1'b0) begin
      bad++;
      $display("FAIL collision: mode=%b score=%0d tick=%b, required 10/3/0",
               bus.game_mode, bus.score, bus.move_tick);
    end
    repeat (20) cyc();
    total++;
    if (bus.game_mode !== 2'b10) begin
      bad++;
      $display("FAIL over_hold: mode=%b, required 10", bus.game_mode);
    end
    press(3);
    total++;
    if (bus.game_mode !== 2'b00 || bus.choice !== 2'd0 || bus.score !== 8'd3) begin
      bad++;
      $display("FAIL over_to_menu: mode=%b choice=%0d score=%0d, required 00/0/3",
               bus.game_mode, bus.choice, bus.score);
    end
    bus.up = 1'b1;
    cyc();
    bus.up = 1'b0;
    total++;
    if (bus.start !== 1'b1 || bus.board_w !== 4'd6 || bus.score !== 8'd0 || bus.game_mode !== 2'b01) begin
      bad++;
      $display("FAIL restart_small: start=%b bw=%0d score=%0d mode=%b, required 1/6/0/01",
               bus.start, bus.board_w, bus.score, bus.game_mode);
    end
  endtask

  task automatic test_reset_hold();
    logic saw_start;
    bus.apple_eaten = 1'b1;
    cyc();
    bus.apple_eaten = 1'b0;
    total++;
    if (bus.score !== 8'd1) begin
      bad++;
      $display("FAIL midgame_score: score=%0d, required 1", bus.score);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.game_mode !== 2'b00 || bus.board_w !== 4'd10 || bus.score !== 8'd0 ||
        bus.start !== 1'b0 || bus.move_tick !== 1'b0 || bus.choice !== 2'd0 || bus.dir !== 2'b00) begin
      bad++;
      $display("FAIL async_reset: mode=%b bw=%0d score=%0d start=%b tick=%b choice=%0d dir=%b, required reset values",
               bus.game_mode, bus.board_w, bus.score, bus.start, bus.move_tick, bus.choice, bus.dir);
    end
    bus.up = 1'b1;
    repeat (2) cyc();
    reset_n = 1'b1;
    saw_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.start === 1'b1) saw_start = 1'b1;
    end
    total++;
    if (saw_start !== 1'b0 || bus.game_mode !== 2'b00) begin
      bad++;
      $display("FAIL held_up: start_seen=%b mode=%b, required 0/00", saw_start, bus.game_mode);
    end
    bus.up = 1'b0;
    cyc();
    exp_q.push_back('{8, 2'b00});
    bus.up = 1'b1;
    cyc();
    bus.up = 1'b0;
    total++;
    if (bus.start !== 1'b1 || bus.game_mode !== 2'b01) begin
      bad++;
      $display("FAIL start_after_release: start=%b mode=%b, required 1/01", bus.start, bus.game_mode);
    end
    wait_drain(20, "final");
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc_n   = 0;
    last_ev = 0;
    test_reset();
    test_menu_start();
    test_idle_ticks();
    test_heading();
    test_apples();
    test_collision();
    test_reset_hold();
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter MOVE_PERIOD, default 10000000: initial clock cycles per move_tick.
REQ-002 SHALL have parameter MIN_PERIOD, default 2000000: floor on the move period.
REQ-003 SHALL have parameter SPEED_STEP, default 500000: period decrement per apple eaten.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ports up, down, left, right, input, 1 each: clk-synchronous button levels, active-high.
REQ-007 SHALL have port collision, input, 1: one-cycle pulse from the datapath (wall or self hit).
REQ-008 SHALL have port apple_eaten, input, 1: one-cycle pulse from the datapath.
REQ-009 SHALL have port game_mode, output, 2: 00 MENU, 01 PLAY, 10 OVER; 11 is never driven.
REQ-010 SHALL have port choice, output, 2: menu selection, range 0..2.
REQ-011 SHALL have port board_w, output, 4: board width in cells (6, 8 or 10).
REQ-012 SHALL have port dir, output, 2: committed heading (00 right, 01 left, 10 up, 11 down).
REQ-013 SHALL have port move_tick, output, 1: one-cycle step strobe to the datapath.
REQ-014 SHALL have port start, output, 1: one-cycle pulse telling the datapath to initialise the snake and apple.
REQ-015 SHALL have port score, output, 8: apples eaten in the current game.

Function
REQ-016 SHALL register each button every cycle; a press is the current level high while the registered level is low.
REQ-017 SHALL act on at most one press per cycle, priority up > down > left > right.
REQ-018 In MENU, a left press SHALL decrement choice, saturating at 0.
REQ-019 In MENU, a right press SHALL increment choice, saturating at 2.
REQ-020 In MENU, a down press SHALL be ignored.
REQ-021 In MENU, an up press SHALL, on the next edge, load board_w (choice 0 gives 6, 1 gives 8, 2 gives 10), pulse start for exactly one cycle, and enter PLAY.
REQ-022 The same MENU up-press edge SHALL set dir=00 and pending heading=00, clear score and the tick counter, and set period=MOVE_PERIOD.
REQ-023 In PLAY, a direction press SHALL update an internal pending heading, unless it is the exact opposite of the committed dir, in which case it SHALL be discarded.
REQ-024 In PLAY, a press in the same direction as the committed dir SHALL be accepted and have no effect.
REQ-025 In PLAY, the tick counter SHALL increment every cycle.
REQ-026 When the tick counter equals period-1, the block SHALL assert move_tick for that one cycle, clear the counter, and commit dir <= pending on the same edge.
REQ-027 A press arriving in the tick cycle SHALL be compared against the dir value before that edge.
REQ-028 apple_eaten in PLAY SHALL increment score, saturating at 255.
REQ-029 apple_eaten in PLAY SHALL reduce period by SPEED_STEP, clamped to MIN_PERIOD; the tick counter SHALL not be disturbed.
REQ-030 collision in PLAY SHALL enter OVER on the next edge; move_tick SHALL be 0 from that edge onward.
REQ-031 If collision and apple_eaten arrive in the same cycle, collision SHALL win and score and period SHALL be unchanged.
REQ-032 collision and apple_eaten SHALL be ignored outside PLAY.
REQ-033 In OVER, any press SHALL return to MENU with choice=0; score SHALL hold its final value until the next start.
REQ-034 A button held across a state change SHALL not generate a second press, because of edge detection.
REQ-035 Period and counter arithmetic SHALL be 24-bit unsigned; the block SHALL never compute a period below MIN_PERIOD, with no underflow.

Reset
REQ-036 While reset_n is low, the block SHALL drive game_mode=00, choice=0, board_w=10, dir=00, pending heading=00, move_tick=0, start=0, score=0, counter=0, period=MOVE_PERIOD.
REQ-037 While reset_n is low, the registered button levels SHALL be 1, so buttons held through reset release are ignored until released.
REQ-038 Reset asserted mid-game SHALL abort immediately to the reset values, with no move_tick or start glitch after deassertion.

Verification (MOVE_PERIOD=8, MIN_PERIOD=4, SPEED_STEP=2)
REQ-039 Bench SHALL cover: right x3, then up in MENU -> choice saturates at 2; board_w=10; start high for exactly 1 cycle; game_mode=01.
REQ-040 Bench SHALL cover: PLAY with no input -> move_tick every 8 cycles; dir stays 00.
REQ-041 Bench SHALL cover: heading right, press left, then press up before the tick -> left discarded; dir becomes 10 at the next tick, not before.
REQ-042 Bench SHALL cover: three apple_eaten pulses -> score=3; tick spacing goes 6, 4, 4 (clamped).
REQ-043 Bench SHALL cover: collision and apple_eaten in the same cycle -> game_mode=10 next edge; score unchanged; no further move_tick.
REQ-044 Bench SHALL cover: up held through reset release -> no start; release then press -> normal start. Reset_n pulsed in PLAY -> all outputs return to reset values asynchronously.
